cordic_phase_gen: RTL and testbench

CORDIC_PHASE_GEN -- requirements
Module: cordic_phase_gen

---
 rtl/cordic_phase_gen.sv | 153 +++++++++++++++
 tb/tb_cordic_phase_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen: phase accumulator and sample-rate divider that feeds a
// rotation-mode CORDIC. On every divider tick it emits a one-cycle strobe,
// the current wrapped phase on z_out, and the 1/K gain seed on x_out/y_out.
//
// Strobe semantics: valid_out is a pure one-cycle qualifier with no ready
// back-pressure. The downstream CORDIC must accept x_out/y_out/z_out in any
// cycle where valid_out=1. Outside those cycles the data outputs keep their
// last values and carry no meaning.
module cordic_phase_gen #(
  parameter int CORDIC_WIDTH          = 16,
  parameter int CORDIC_INTERNAL_WIDTH = 20,
  parameter int DIV_WIDTH             = 16,
  parameter int PHASE_PI              = 205887,
  parameter int X_SEED                = 19898
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    enable,
  input  logic                                    freq_load,
  input  logic signed [CORDIC_INTERNAL_WIDTH-1:0] freq_word,
  input  logic        [DIV_WIDTH-1:0]             rate_div,
  input  logic                                    phase_clear,
  output logic                                    valid_out,
  output logic signed [CORDIC_WIDTH-1:0]          x_out,
  output logic signed [CORDIC_WIDTH-1:0]          y_out,
  output logic signed [CORDIC_INTERNAL_WIDTH-1:0] z_out,
  output logic                                    running
);

  localparam int IW = CORDIC_INTERNAL_WIDTH;
  localparam int CW = CORDIC_WIDTH;

  // pi at accumulator width (for saturating the increment) and at sum width
  // (one guard bit, for wrapping the sum)
  localparam logic signed [IW-1:0] PI_N     = IW'(PHASE_PI);
  localparam logic signed [IW:0]   PI_W     = (IW+1)'(PHASE_PI);
  localparam logic signed [IW:0]   TWO_PI_W = (IW+1)'(2 * PHASE_PI);
  localparam logic signed [CW-1:0] X_SEED_W = CW'(X_SEED);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state;
  logic [DIV_WIDTH-1:0]  cnt;
  logic signed [IW-1:0]  phase;
  logic signed [IW-1:0]  inc;
  logic signed [IW-1:0]  pend_inc;
  logic                  pend_valid;

  logic signed [IW-1:0]  fw_sat;
  logic signed [IW-1:0]  inc_next;
  logic signed [IW:0]    sum;
  logic signed [IW:0]    sum_wrap;
  logic                  tick;

  // Clamp the incoming frequency word to [-pi, pi]
  always_comb begin
    fw_sat = freq_word;
    if (freq_word > PI_N) begin
      fw_sat = PI_N;
    end else if (freq_word < -PI_N) begin
      fw_sat = -PI_N;
    end
  end

  // Tick decision, the increment used at a tick, and the wrapped next phase
  always_comb begin
    // A load in the tick cycle wins over an older pending load
    tick     = (state == RUN) && enable && !phase_clear && (cnt >= rate_div);
    inc_next = inc;
    if (freq_load) begin
      inc_next = fw_sat;
    end else if (pend_valid) begin
      inc_next = pend_inc;
    end
    sum      = {phase[IW-1], phase} + {inc_next[IW-1], inc_next};
    sum_wrap = sum;
    if (sum > PI_W) begin
      sum_wrap = sum - TWO_PI_W;
    end else if (sum <= -PI_W) begin
      sum_wrap = sum + TWO_PI_W;
    end
  end

  // FSM, divider, phase accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      running    <= 1'b0;
      valid_out  <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      z_out      <= '0;
      phase      <= '0;
      inc        <= '0;
      pend_inc   <= '0;
      pend_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      valid_out <= 1'b0;

      // Loads always land in the pending register; a tick in the same
      // cycle consumes it immediately, so it is not left pending
      if (freq_load) begin
        pend_inc <= fw_sat;
        if (!tick) begin
          pend_valid <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state   <= RUN;
            running <= 1'b1;
            cnt     <= '0;
          end
        end
        RUN: begin
          if (!enable) begin
            // Leaving RUN: no tick, phase and increment are kept
            state   <= IDLE;
            running <= 1'b0;
          end else if (tick) begin
            valid_out  <= 1'b1;
            z_out      <= phase;
            x_out      <= X_SEED_W;
            y_out      <= '0;
            phase      <= sum_wrap[IW-1:0];
            inc        <= inc_next;
            pend_valid <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase

      // Phase restart overrides the divider and any tick in this cycle
      if (phase_clear) begin
        phase <= '0;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed testbench for cordic_phase_gen with hand-computed expected values.
module tb_cordic_phase_gen;

  localparam int CW = 16;
  localparam int IW = 20;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic                 freq_load;
  logic signed [IW-1:0] freq_word;
  logic [DW-1:0]        rate_div;
  logic                 phase_clear;
  logic                 valid_out;
  logic signed [CW-1:0] x_out;
  logic signed [CW-1:0] y_out;
  logic signed [IW-1:0] z_out;
  logic                 running;

  int checks   = 0;
  int failures = 0;

  logic [IW-1:0] exp_q[$];

  cordic_phase_gen #(
    .CORDIC_WIDTH(CW),
    .CORDIC_INTERNAL_WIDTH(IW),
    .DIV_WIDTH(DW),
    .PHASE_PI(205887),
    .X_SEED(19898)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .freq_load(freq_load),
    .freq_word(freq_word),
    .rate_div(rate_div),
    .phase_clear(phase_clear),
    .valid_out(valid_out),
    .x_out(x_out),
    .y_out(y_out),
    .z_out(z_out),
    .running(running)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one edge, sample 1ns later, drop one-cycle strobes
  task automatic step();
    @(posedge clk);
    #1;
    freq_load   = 1'b0;
    phase_clear = 1'b0;
  endtask

  task automatic expect_quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      check_eq({tag, "_quiet"}, valid_out, 0);
    end
  endtask

  task automatic expect_strobe(input int exp_z, input string tag);
    step();
    check_eq({tag, "_valid"}, valid_out, 1);
    check_eq({tag, "_z"}, z_out, exp_z);
    check_eq({tag, "_x"}, x_out, 19898);
    check_eq({tag, "_y"}, y_out, 0);
  endtask

  int z36[4] = '{-102942, -51470, 2, 51474};

  initial begin
    rst = 1'b1; enable = 1'b0; freq_load = 1'b0; freq_word = '0;
    rate_div = '0; phase_clear = 1'b0;
    step();
    step();
    check_eq("rst_valid", valid_out, 0);
    check_eq("rst_x", x_out, 0);
    check_eq("rst_y", y_out, 0);
    check_eq("rst_z", z_out, 0);
    check_eq("rst_running", running, 0);

    // continuous strobes, rate_div=0
    rst = 1'b0; rate_div = 0; freq_word = 51472; freq_load = 1'b1; enable = 1'b1;
    step();
    check_eq("enter_running", running, 1);
    check_eq("enter_valid", valid_out, 0);
    exp_q.push_back(IW'(0));
    exp_q.push_back(IW'(51472));
    exp_q.push_back(IW'(102944));
    exp_q.push_back(IW'(154416));
    exp_q.push_back(IW'(-205886));
    exp_q.push_back(IW'(-154414));
    while (exp_q.size() > 0) begin
      logic signed [IW-1:0] e;
      e = exp_q.pop_front();
      expect_strobe(int'(e), "cont");
    end

    // rate_div=3: one strobe every 4 cycles
    rate_div = 3;
    for (int i = 0; i < 16; i++) begin
      step();
      check_eq("div4_valid", valid_out, (i % 4 == 3) ? 1 : 0);
      if (i % 4 == 3) check_eq("div4_z", z_out, z36[i / 4]);
    end

    // saturating load mid-period, effective at next strobe
    freq_word = 300000; freq_load = 1'b1;
    expect_quiet(3, "sat");
    expect_strobe(102946, "sat_t1");
    expect_quiet(3, "sat");
    expect_strobe(-102941, "sat_t2");
    // load coincident with a tick is used by that tick
    expect_quiet(3, "coinc");
    freq_word = 51472; freq_load = 1'b1;
    expect_strobe(102946, "coinc_t1");
    expect_quiet(3, "coinc");
    expect_strobe(154418, "coinc_t2");

    // phase_clear on a tick cycle, with a coincident negative saturating load
    expect_quiet(3, "clr_pre");
    phase_clear = 1'b1; freq_word = -300000; freq_load = 1'b1;
    step();
    check_eq("clr_suppress", valid_out, 0);
    expect_quiet(3, "clr");
    expect_strobe(0, "negpi_t1");
    expect_quiet(3, "negpi");
    expect_strobe(205887, "negpi_t2");
    expect_quiet(3, "negpi");
    expect_strobe(0, "negpi_t3");

    // drop enable mid-run with phase held at +pi, then resume
    expect_quiet(1, "drop_pre");
    enable = 1'b0;
    step();
    check_eq("drop_running", running, 0);
    check_eq("drop_valid", valid_out, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("idle_running", running, 0);
      check_eq("idle_valid", valid_out, 0);
    end
    enable = 1'b1;
    step();
    check_eq("resume_running", running, 1);
    check_eq("resume_valid", valid_out, 0);
    expect_quiet(3, "resume");
    expect_strobe(205887, "resume_t1");
    expect_quiet(3, "resume");
    expect_strobe(0, "resume_t2");

    // reset mid-run with a load in flight
    expect_quiet(2, "rst_pre");
    rst = 1'b1; freq_word = 51472; freq_load = 1'b1;
    step();
    check_eq("midrst_valid", valid_out, 0);
    check_eq("midrst_x", x_out, 0);
    check_eq("midrst_y", y_out, 0);
    check_eq("midrst_z", z_out, 0);
    check_eq("midrst_running", running, 0);
    rst = 1'b0;
    step();
    check_eq("post_rst_running", running, 1);
    expect_quiet(3, "post_rst");
    expect_strobe(0, "post_rst_t1");
    expect_quiet(3, "post_rst");
    expect_strobe(0, "post_rst_t2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
